// File: rtl/othello_pkg.sv
// Shared constants for the othello board: pattern selects, palette and
// board geometry. The datapath and the cell drawer both import this.
package othello_pkg;

    // Geometry
    localparam int CELL_SIZE    = 12;   // pixels per cell side
    localparam int CELL_PITCH   = 13;   // cell plus one pixel of grid line
    localparam int BOARD_ORIGIN = 9;    // screen offset of the first cell
    localparam int DISK_R2X4    = 100;  // disk radius test, in doubled units

    // Pattern to draw into a cell
    typedef enum logic [1:0] {
        SEL_EMPTY  = 2'd0,
        SEL_BOX    = 2'd1,
        SEL_DISK_A = 2'd2,
        SEL_DISK_B = 2'd3
    } sel_t;

    typedef logic [2:0] colour_t;

    // Palette, RGB
    localparam colour_t C_BOARD  = 3'b010;
    localparam colour_t C_BOX    = 3'b110;
    localparam colour_t C_DISK_A = 3'b000;
    localparam colour_t C_DISK_B = 3'b111;

endpackage

// File: rtl/cell_drawer_if.sv
// Request handshake and pixel stream between the control logic, the cell
// drawer and the vga_adapter.
interface cell_drawer_if;

    logic       start;
    logic [7:0] x_base;
    logic [6:0] y_base;
    logic [1:0] select;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    modport master (
        output start, x_base, y_base, select,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  start, x_base, y_base, select,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/cell_pixel_shader.sv
// Colour of one pixel inside a 12x12 cell, given its offset and the
// pattern select. Purely combinational so it can be tested on its own.
module cell_pixel_shader
    import othello_pkg::*;
(
    input  logic [3:0] dx,
    input  logic [3:0] dy,
    input  sel_t       select,
    output colour_t    colour
);

    localparam logic [3:0] LAST = 4'(CELL_SIZE - 1);

    // Offsets from the cell centre in doubled units, so the centre lands on
    // an integer: 2d-11 ranges over -11..11 and fits 5 bits signed.
    logic [4:0] off_x, off_y;
    logic [4:0] mag_x, mag_y;
    logic [7:0] sq_x, sq_y, dist2;
    logic       on_edge, in_disk;

    assign off_x = {dx, 1'b0} - 5'd11;
    assign off_y = {dy, 1'b0} - 5'd11;
    assign mag_x = off_x[4] ? 5'(-off_x) : off_x;
    assign mag_y = off_y[4] ? 5'(-off_y) : off_y;
    assign sq_x  = {3'b000, mag_x} * {3'b000, mag_x};
    assign sq_y  = {3'b000, mag_y} * {3'b000, mag_y};
    assign dist2 = sq_x + sq_y;   // at most 242, no overflow in 8 bits

    assign on_edge = (dx == 4'd0) || (dx == LAST) || (dy == 4'd0) || (dy == LAST);
    assign in_disk = (dist2 <= 8'(DISK_R2X4));

    // Pick the pattern colour; anything not covered shows the board colour
    always_comb begin
        colour = C_BOARD;
        case (select)
            SEL_EMPTY:  colour = C_BOARD;
            SEL_BOX:    colour = on_edge ? C_BOX : C_BOARD;
            SEL_DISK_A: colour = in_disk ? C_DISK_A : C_BOARD;
            SEL_DISK_B: colour = in_disk ? C_DISK_B : C_BOARD;
            default:    colour = C_BOARD;
        endcase
    end

endmodule

// File: rtl/cell_drawer.sv
// Rasterises one 12x12 board cell, one registered pixel per clock, with a
// start/busy/done handshake for the sequencing FSM upstream.
module cell_drawer
    import othello_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,   // asynchronous, active-high
    cell_drawer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(CELL_SIZE - 1);

    state_t     state;
    logic [3:0] dx, dy;
    logic [7:0] x_lat;
    logic [6:0] y_lat;
    sel_t       sel_lat;
    colour_t    pix_colour;

    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    colour_t    vga_colour_q;
    logic       vga_plot_q, busy_q, done_q;

    cell_pixel_shader u_shader (
        .dx     (dx),
        .dy     (dy),
        .select (sel_lat),
        .colour (pix_colour)
    );

    // Sequencer: latch request, walk the cell in raster order, pulse done
    // NOTE: every register, including the request latch, is cleared by reset
    // so the outputs read 0 until a new start; all state uses non-blocking
    // assignments so the registers update together at the edge.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state        <= IDLE;
            dx           <= 4'd0;
            dy           <= 4'd0;
            x_lat        <= 8'd0;
            y_lat        <= 7'd0;
            sel_lat      <= SEL_EMPTY;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vga_plot_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    if (bus.start) begin
                        x_lat   <= bus.x_base;
                        y_lat   <= bus.y_base;
                        sel_lat <= sel_t'(bus.select);
                        dx      <= 4'd0;
                        dy      <= 4'd0;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    vga_x_q      <= x_lat + {4'b0000, dx};
                    vga_y_q      <= y_lat + {3'b000, dy};
                    vga_colour_q <= pix_colour;
                    vga_plot_q   <= 1'b1;
                    busy_q       <= 1'b1;
                    done_q       <= 1'b0;
                    if (dx == LAST) begin
                        dx <= 4'd0;
                        if (dy == LAST) begin
                            dy    <= 4'd0;
                            state <= DONE;
                        end else begin
                            dy <= dy + 4'd1;
                        end
                    end else begin
                        dx <= dx + 4'd1;
                    end
                end
                DONE: begin
                    vga_plot_q <= 1'b0;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    vga_plot_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_cell_drawer.sv
// Self-checking bench for cell_drawer: reset state, spot pixels from a
// table, full-cell comparison against a reference model on random cells,
// and hand sequences for ignored starts, back-to-back starts and reset
// during a draw.
module tb_cell_drawer;
    import othello_pkg::*;

    logic clock  = 1'b0;
    logic resetn = 1'b1;

    cell_drawer_if bus ();

    cell_drawer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Pixels seen during the most recent draw
    logic [7:0] cap_x[$];
    logic [6:0] cap_y[$];
    logic [2:0] cap_c[$];
    int         cap_t[$];
    int         done_cnt, done_cyc, busy_bad;
    logic       chain_ok;
    localparam logic [7:0] CHAIN_X = 8'd60;

    typedef struct {
        logic [7:0] xb;
        logic [6:0] yb;
        logic [1:0] sel;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] col;
    } spot_t;

    spot_t spots[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference colour from the geometric rules, in plain integer arithmetic
    function automatic logic [2:0] model_colour(input logic [1:0] sel, input int dx, input int dy);
        int r2;
        bit edge_px;
        r2 = (2 * dx - 11) * (2 * dx - 11) + (2 * dy - 11) * (2 * dy - 11);
        edge_px = (dx == 0) || (dx == 11) || (dy == 0) || (dy == 11);
        case (sel)
            2'd1:    return edge_px ? 3'b110 : 3'b010;
            2'd2:    return (r2 <= 100) ? 3'b000 : 3'b010;
            2'd3:    return (r2 <= 100) ? 3'b111 : 3'b010;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] all_outputs();
        return 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done});
    endfunction

    // One request, observed for 150 cycles after acceptance. poke_at pulses
    // start and scrambles inputs mid-draw, reset_at asserts reset after that
    // pixel, chain issues the next start during the done cycle.
    task automatic draw(input logic [7:0] xb, input logic [6:0] yb, input logic [1:0] sel,
                        input int poke_at, input int reset_at, input bit chain);
        logic exp_busy;
        cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_t.delete();
        done_cnt = 0; done_cyc = -1; busy_bad = 0; chain_ok = 1'b0;
        @(negedge clock);
        bus.x_base = xb; bus.y_base = yb; bus.select = sel; bus.start = 1'b1;
        @(negedge clock);              // cycle 0: accepted, busy not yet up
        bus.start = 1'b0;
        if (bus.busy !== 1'b0 || bus.vga_plot !== 1'b0) busy_bad++;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clock);
            if (reset_at > 0 && c > reset_at) exp_busy = 1'b0;
            else exp_busy = (c <= 145) || (chain && c >= 147);
            if (bus.busy !== exp_busy) busy_bad++;
            if (bus.vga_plot === 1'b1 && c <= 145) begin
                cap_x.push_back(bus.vga_x); cap_y.push_back(bus.vga_y);
                cap_c.push_back(bus.vga_colour); cap_t.push_back(c);
            end
            if (bus.vga_plot === 1'b1 && c > 145 && !chain) busy_bad++;
            if (bus.done === 1'b1) begin done_cnt++; done_cyc = c; end
            if (chain && c == 147) chain_ok = (bus.vga_plot === 1'b1) && (bus.vga_x === CHAIN_X);
            if (c == poke_at) begin
                bus.start = 1'b1; bus.x_base = ~xb; bus.select = sel + 2'd1;
            end
            if (c == poke_at + 1) bus.start = 1'b0;
            if (chain && c == 145) begin
                bus.x_base = CHAIN_X; bus.select = 2'd0; bus.start = 1'b1;
            end
            if (chain && c == 146) bus.start = 1'b0;
            if (c == reset_at) begin
                resetn = 1'b1;
                #1 check("reset_mid_outputs", all_outputs(), 32'd0);
            end
            if (reset_at > 0 && c == reset_at + 1) resetn = 1'b0;
        end
    endtask

    task automatic verify_capture(input string tag, input logic [7:0] xb, input logic [6:0] yb,
                                  input logic [1:0] sel, input int n);
        int late;
        late = 0;
        check({tag, "_count"}, 32'(cap_x.size()), 32'(n));
        for (int i = 0; i < n && i < cap_x.size(); i++) begin
            int dx, dy;
            logic [7:0] ex;
            logic [6:0] ey;
            dx = i % 12; dy = i / 12;
            ex = xb + 8'(dx);
            ey = yb + 7'(dy);
            check($sformatf("%s_px%0d", tag, i),
                  32'({cap_x[i], cap_y[i], cap_c[i]}),
                  32'({ex, ey, model_colour(sel, dx, dy)}));
            if (cap_t[i] != i + 1) late++;
        end
        check({tag, "_pixel_timing"}, 32'(late), 32'd0);
    endtask

    task automatic verify_handshake(input string tag);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'd145);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_profile"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        logic [7:0] org_a, org_b;
        int found;
        logic [2:0] found_col;
        bit got_done;

        org_a = 8'(BOARD_ORIGIN);
        org_b = 8'(BOARD_ORIGIN + CELL_PITCH);

        spots[0] = '{org_b, 7'd9, 2'd1, 8'd22, 7'd9,  3'b110};
        spots[1] = '{org_b, 7'd9, 2'd1, 8'd23, 7'd10, 3'b010};
        spots[2] = '{org_b, 7'd9, 2'd1, 8'd33, 7'd20, 3'b110};
        spots[3] = '{org_b, 7'd9, 2'd1, 8'd27, 7'd20, 3'b110};
        spots[4] = '{org_a, 7'd9, 2'd2, 8'd14, 7'd14, 3'b000};
        spots[5] = '{org_a, 7'd9, 2'd2, 8'd9,  7'd9,  3'b010};
        spots[6] = '{org_a, 7'd9, 2'd2, 8'd9,  7'd14, 3'b010};
        spots[7] = '{org_a, 7'd9, 2'd2, 8'd10, 7'd14, 3'b000};
        spots[8] = '{org_a, 7'd9, 2'd3, 8'd14, 7'd14, 3'b111};

        bus.start = 1'b0; bus.x_base = 8'd0; bus.y_base = 7'd0; bus.select = 2'd0;

        // Reset state
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("reset_vga_x", 32'(bus.vga_x), 32'd0);
        check("reset_vga_y", 32'(bus.vga_y), 32'd0);
        check("reset_colour", 32'(bus.vga_colour), 32'd0);
        check("reset_plot", 32'(bus.vga_plot), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);

        // Empty cell at the board origin
        draw(org_a, 7'd9, 2'd0, 0, 0, 1'b0);
        verify_capture("empty", org_a, 7'd9, 2'd0, 144);
        verify_handshake("empty");

        // Spot pixels for box and disk patterns
        foreach (spots[k]) begin
            draw(spots[k].xb, spots[k].yb, spots[k].sel, 0, 0, 1'b0);
            found = 0; found_col = 3'd0;
            for (int i = 0; i < cap_x.size(); i++)
                if (cap_x[i] == spots[k].px && cap_y[i] == spots[k].py) begin
                    found++; found_col = cap_c[i];
                end
            check($sformatf("spot%0d_hits", k), 32'(found), 32'd1);
            check($sformatf("spot%0d_colour", k), 32'(found_col), 32'(spots[k].col));
        end

        // Random cells, including origins that wrap the coordinate range
        for (int r = 0; r < 12; r++) begin
            logic [7:0] rx;
            logic [6:0] ry;
            logic [1:0] rs;
            rx = 8'($urandom_range(0, 255));
            ry = 7'($urandom_range(0, 127));
            rs = 2'($urandom_range(0, 3));
            draw(rx, ry, rs, 0, 0, 1'b0);
            verify_capture($sformatf("rand%0d", r), rx, ry, rs, 144);
            verify_handshake($sformatf("rand%0d", r));
        end

        // Start and input changes mid-draw are ignored; start in the done
        // cycle is accepted at the following edge
        draw(8'd35, 7'd48, 2'd1, 20, 0, 1'b1);
        verify_capture("poke", 8'd35, 7'd48, 2'd1, 144);
        verify_handshake("poke");
        check("chain_accepted", 32'(chain_ok), 32'd1);
        got_done = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) got_done = 1'b1;
        end
        check("chain_finishes", 32'(got_done), 32'd1);
        @(negedge clock);

        // Reset during a draw aborts it without a done pulse
        draw(8'd48, 7'd61, 2'd2, 0, 50, 1'b0);
        check("abort_pixels", 32'(cap_x.size()), 32'd50);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_busy_profile", 32'(busy_bad), 32'd0);
        draw(8'd48, 7'd61, 2'd3, 0, 0, 1'b0);
        verify_capture("after_abort", 8'd48, 7'd61, 2'd3, 144);
        verify_handshake("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
